// File: rtl/hack_cpu.sv
// Multi-cycle Hack CPU: one instruction at a time over separate request/ack
// instruction and data ports, with the standard 16-bit Hack ALU.

module hack_alu (
    input  logic [15:0] x_i,
    input  logic [15:0] y_i,
    input  logic        zx_i,
    input  logic        nx_i,
    input  logic        zy_i,
    input  logic        ny_i,
    input  logic        f_i,
    input  logic        no_i,
    output logic [15:0] out_o,
    output logic        zr_o,
    output logic        ng_o
);
    logic [15:0] x1, x2, y1, y2, f_out;

    always_comb begin
        x1    = zx_i ? 16'h0000 : x_i;
        x2    = nx_i ? ~x1 : x1;
        y1    = zy_i ? 16'h0000 : y_i;
        y2    = ny_i ? ~y1 : y1;
        f_out = f_i ? (x2 + y2) : (x2 & y2);
        out_o = no_i ? ~f_out : f_out;
        zr_o  = (out_o == 16'h0000);
        ng_o  = out_o[15];
    end
endmodule

module hack_cpu (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [14:0] imem_addr,
    input  logic        imem_ack,
    input  logic [15:0] imem_data,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [14:0] dmem_addr,
    output logic [15:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [15:0] dmem_rdata,
    output logic [14:0] pc_o,
    output logic [15:0] a_o,
    output logic [15:0] d_o,
    output logic        retire,
    output logic [2:0]  state_o
);
    // Handshake: a req is raised from a register and holds its addr/we/wdata
    // until ack is seen high at a rising edge; ack may arrive in the very
    // first req cycle, and an ack while the matching req is low is ignored.
    typedef enum logic [2:0] {BOOT, FETCH, MREAD, EXEC, MWRITE} state_e;

    state_e      state_q;
    logic [14:0] pc_q;
    logic [15:0] a_q, d_q, ir_q, m_q, r_q;
    logic        imem_req_q, dmem_req_q, dmem_we_q;

    logic [15:0] alu_y, alu_out;
    logic        alu_zr, alu_ng;
    logic [15:0] commit_val_d;
    logic        flag_zr, flag_ng, jump;
    logic [14:0] pc_inc, commit_pc_d;

    assign alu_y = ir_q[12] ? m_q : a_q;

    hack_alu u_alu (
        .x_i   (d_q),
        .y_i   (alu_y),
        .zx_i  (ir_q[11]),
        .nx_i  (ir_q[10]),
        .zy_i  (ir_q[9]),
        .ny_i  (ir_q[8]),
        .f_i   (ir_q[7]),
        .no_i  (ir_q[6]),
        .out_o (alu_out),
        .zr_o  (alu_zr),
        .ng_o  (alu_ng)
    );

    // In MWRITE the result comes from R, latched in EXEC; flags follow it.
    always_comb begin
        commit_val_d = (state_q == MWRITE) ? r_q : alu_out;
        flag_zr      = (state_q == MWRITE) ? (r_q == 16'h0000) : alu_zr;
        flag_ng      = (state_q == MWRITE) ? r_q[15] : alu_ng;
        jump         = (ir_q[2] & flag_ng) | (ir_q[1] & flag_zr) | (ir_q[0] & ~flag_ng & ~flag_zr);
        pc_inc       = pc_q + 15'd1;
        commit_pc_d  = jump ? a_q[14:0] : pc_inc;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= BOOT;
            pc_q       <= '0;
            a_q        <= '0;
            d_q        <= '0;
            ir_q       <= '0;
            m_q        <= '0;
            r_q        <= '0;
            imem_req_q <= 1'b0;
            dmem_req_q <= 1'b0;
            dmem_we_q  <= 1'b0;
        end else begin
            case (state_q)
                BOOT: begin
                    state_q    <= FETCH;
                    imem_req_q <= 1'b1;
                end
                FETCH: begin
                    if (imem_ack) begin
                        ir_q       <= imem_data;
                        imem_req_q <= 1'b0;
                        if (imem_data[15] & imem_data[12]) begin
                            state_q    <= MREAD;
                            dmem_req_q <= 1'b1;
                            dmem_we_q  <= 1'b0;
                        end else begin
                            state_q <= EXEC;
                        end
                    end
                end
                MREAD: begin
                    if (dmem_ack) begin
                        m_q        <= dmem_rdata;
                        dmem_req_q <= 1'b0;
                        state_q    <= EXEC;
                    end
                end
                EXEC: begin
                    if (!ir_q[15]) begin
                        a_q        <= {1'b0, ir_q[14:0]};
                        pc_q       <= pc_inc;
                        state_q    <= FETCH;
                        imem_req_q <= 1'b1;
                    end else begin
                        r_q <= alu_out;
                        if (ir_q[3]) begin
                            state_q    <= MWRITE;
                            dmem_req_q <= 1'b1;
                            dmem_we_q  <= 1'b1;
                        end else begin
                            if (ir_q[5]) a_q <= commit_val_d;
                            if (ir_q[4]) d_q <= commit_val_d;
                            pc_q       <= commit_pc_d;
                            state_q    <= FETCH;
                            imem_req_q <= 1'b1;
                        end
                    end
                end
                MWRITE: begin
                    if (dmem_ack) begin
                        if (ir_q[5]) a_q <= commit_val_d;
                        if (ir_q[4]) d_q <= commit_val_d;
                        pc_q       <= commit_pc_d;
                        dmem_req_q <= 1'b0;
                        dmem_we_q  <= 1'b0;
                        state_q    <= FETCH;
                        imem_req_q <= 1'b1;
                    end
                end
                default: begin
                    state_q    <= BOOT;
                    imem_req_q <= 1'b0;
                    dmem_req_q <= 1'b0;
                    dmem_we_q  <= 1'b0;
                end
            endcase
        end
    end

    // Retire marks the commit cycle itself; new PC/A/D appear after that edge.
    assign retire     = ((state_q == EXEC) && (!ir_q[15] || !ir_q[3])) ||
                        ((state_q == MWRITE) && dmem_ack);
    assign imem_req   = imem_req_q;
    assign imem_addr  = pc_q;
    assign dmem_req   = dmem_req_q;
    assign dmem_we    = dmem_we_q;
    assign dmem_addr  = a_q[14:0];
    assign dmem_wdata = r_q;
    assign pc_o       = pc_q;
    assign a_o        = a_q;
    assign d_o        = d_q;
    assign state_o    = state_q;
endmodule

// File: doc/hack_cpu.md
HACK_CPU -- requirements
Module: hack_cpu

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock.
REQ-002 SHALL have ports: rst_n  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have ports: imem_req  out  1  instruction fetch request.
REQ-004 SHALL have ports: imem_addr  out  15  fetch address (= PC).
REQ-005 SHALL have ports: imem_ack  in  1  fetch complete; imem_data valid this cycle.
REQ-006 SHALL have ports: imem_data  in  16  instruction word.
REQ-007 SHALL have ports: dmem_req  out  1  data request.
REQ-008 SHALL have ports: dmem_we  out  1  1 = write, 0 = read.
REQ-009 SHALL have ports: dmem_addr  out  15  data address (= A[14:0]).
REQ-010 SHALL have ports: dmem_wdata  out  16  write data.
REQ-011 SHALL have ports: dmem_ack  in  1  data complete; dmem_rdata valid on reads.
REQ-012 SHALL have ports: dmem_rdata  in  16  read data.
REQ-013 SHALL have ports: pc_o  out  15, a_o  out  16, d_o  out  16  architectural PC/A/D.
REQ-014 SHALL have ports: retire  out  1  one-cycle pulse per committed instruction.

Function
REQ-015 SHALL hold registers: PC (15b), A (16b), D (16b), IR (16b), M (16b), R (16b ALU result latch), and state ∈ {BOOT, FETCH, MREAD, EXEC, MWRITE}.
REQ-016 SHALL instantiate the team 16-bit Hack ALU: x = D, y = (IR[12] ? M : A), zx/nx/zy/ny/f/no = IR[11:6]; zr and ng are consumed for jumps.
REQ-017 BOOT: imem_req = 0 and dmem_req = 0; unconditionally go to FETCH next cycle.
REQ-018 FETCH: imem_req = 1, imem_addr = PC. On imem_ack = 1, latch IR ← imem_data. Next state: MREAD if imem_data[15] & imem_data[12], else EXEC. Stay in FETCH while ack = 0.
REQ-019 MREAD: dmem_req = 1, dmem_we = 0, dmem_addr = A[14:0]. On dmem_ack, latch M ← dmem_rdata and go to EXEC.
REQ-020 EXEC, A-instruction (IR[15] = 0): A ← {1'b0, IR[14:0]}, PC ← PC+1, retire = 1, go to FETCH.
REQ-021 EXEC, C-instruction: latch R ← alu out. If IR[3] (dest M), go to MWRITE without committing. Otherwise commit (REQ-023) and go to FETCH.
REQ-022 MWRITE: dmem_req = 1, dmem_we = 1, dmem_addr = A[14:0] (pre-instruction A), dmem_wdata = R. On dmem_ack, commit (REQ-023) and go to FETCH.
REQ-023 Commit: if IR[5], A ← R; if IR[4], D ← R. Jump = (IR[2] & ng) | (IR[1] & zr) | (IR[0] & ~ng & ~zr), with flags from R. PC ← jump ? old A[14:0] : PC+1. retire = 1 for that cycle.
REQ-024 Jump target and dmem_addr SHALL use A before any same-instruction A update.
REQ-025 IR[14:13] SHALL be ignored.
REQ-026 PC arithmetic is 15-bit modulo: 0x7FFF+1 → 0x0000.
REQ-027 Requests SHALL hold address, data and we stable until ack is sampled high. Ack in the same cycle as req (zero wait) SHALL be legal. Acks while the matching req is low SHALL be ignored.
REQ-028 Minimum latencies in cycles, FETCH to next FETCH, zero wait: A-instr 2; C-instr 2; C with a=1 3; with dest M 3; both 4.
REQ-029 dmem_req and imem_req SHALL never be high together.

Reset
REQ-030 rst_n low SHALL immediately force: state = BOOT, PC = 0, A = 0, D = 0, IR = 0, M = 0, R = 0, all req/we = 0, retire = 0.
REQ-031 Reset mid-transaction SHALL abandon the transaction with no commit. After release, execution restarts at PC 0 via BOOT.

Verification
REQ-032 Reset, then imem[0] = 0x0005, imem[1] = 0xEC10 (D=A), zero wait -> two retires; A = 5, D = 5, PC = 2, no dmem_req.
REQ-033 imem_ack delayed 3 cycles on every fetch -> imem_req and imem_addr stable throughout, no retire until ack, same final state as REQ-032.
REQ-034 @100, D=A, 0xE7C8 (M=D+1) -> single dmem write: addr 100, wdata 101, we = 1. A = 100, D = 100, PC = 3.
REQ-035 @10, 0xEA87 (0;JMP) -> PC = 10. Then D = 0 and 0xE302 (D;JEQ) -> jump taken. With D = 1 -> PC+1.
REQ-036 A = 7, dmem[7] = 3, 0xFCA8 (AM=M-1) -> read addr 7, then write addr 7 data 2, then A = 2, retire once.
REQ-037 rst_n low while in MWRITE with ack withheld -> dmem_req drops asynchronously; PC/A/D = 0; no write observed; refetch from 0 after BOOT.
